// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: measures the falling-edge spacing of a received 0x55
// sync character and programs the UART 16x baud generator (13-bit divider plus
// 3-bit eighths fraction). A default divider is driven until a measurement locks.
module uart_autobaud_ctrl #(
    parameter logic [12:0] DEFAULT_BAUD_VAL = 13'd1,
    parameter logic [2:0]  DEFAULT_FRACTION = 3'd0,
    parameter logic [19:0] TIMEOUT_CYCLES   = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        start,
    input  logic        abort,
    output logic [12:0] baud_val,
    output logic [2:0]  baud_val_fraction,
    output logic        busy,
    output logic        locked,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        CALC    = 2'd3
    } state_t;

    localparam logic [19:0] CNT_MAX = 20'hFFFFF;

    state_t      state;
    state_t      state_next;

    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic        fe;

    logic [19:0] total;
    logic [19:0] icnt;
    logic [19:0] i1;
    logic [1:0]  edge_cnt;

    logic [20:0] elapsed;
    logic [19:0] i_cur;
    logic [19:0] diff;
    logic [20:0] r;
    logic [13:0] q;
    logic [13:0] q_m1;

    logic        fail;
    logic        calc_ok;

    // Rounding bits below the fraction and the borrow bit of q-1 carry no
    // information once q is range-checked; gathered here so they read as used.
    logic        unused_bits;
    assign unused_bits = ^{r[3:0], q_m1[13]};

    // Cycles elapsed since the previous falling edge, counting the detection cycle.
    assign elapsed = {1'b0, icnt} + 21'd1;
    assign i_cur   = elapsed[19:0];
    assign diff    = (i_cur >= i1) ? (i_cur - i1) : (i1 - i_cur);

    // Divider arithmetic: total is 8 bit periods, so total/128 is one 16x tick.
    assign r    = {1'b0, total} + 21'd8;
    assign q    = r[20:7];
    assign q_m1 = q - 14'd1;

    assign fe   = rx_prev & ~rx_sync;
    assign busy = (state == ARM) || (state == MEASURE);

    // Two-flop synchronizer on the asynchronous rx line plus edge-detect history.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples
        // the pre-edge values of the others, exactly as the hardware does.
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic with fail / calculation-complete decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_next = state;
        fail       = 1'b0;
        calc_ok    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (fe) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (elapsed >= {1'b0, TIMEOUT_CYCLES}) begin
                    fail = 1'b1;
                end else if (fe) begin
                    if ((edge_cnt != 2'd0) && (diff > (i1 >> 2))) begin
                        fail = 1'b1;
                    end else if (edge_cnt == 2'd3) begin
                        state_next = CALC;
                    end
                end
                if (fail) begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                state_next = IDLE;
                if ((q == 14'd0) || (q > 14'd8192)) begin
                    fail = 1'b1;
                end else begin
                    calc_ok = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Measurement counters, divider outputs and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total             <= '0;
            icnt              <= '0;
            i1                <= '0;
            edge_cnt          <= '0;
            baud_val          <= DEFAULT_BAUD_VAL;
            baud_val_fraction <= DEFAULT_FRACTION;
            locked            <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            done <= fail | calc_ok;
            if (fail) begin
                error <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        error    <= 1'b0;
                        edge_cnt <= '0;
                    end
                end
                ARM: begin
                    if (!abort && fe) begin
                        total    <= '0;
                        icnt     <= '0;
                        edge_cnt <= '0;
                    end
                end
                MEASURE: begin
                    if (!abort) begin
                        total <= (total == CNT_MAX) ? total : total + 20'd1;
                        if (fe) begin
                            icnt     <= '0;
                            edge_cnt <= edge_cnt + 2'd1;
                            if (edge_cnt == 2'd0) begin
                                i1 <= i_cur;
                            end
                        end else begin
                            icnt <= (icnt == CNT_MAX) ? icnt : icnt + 20'd1;
                        end
                    end
                end
                CALC: begin
                    if (calc_ok) begin
                        baud_val          <= q_m1[12:0];
                        baud_val_fraction <= r[6:4];
                        locked            <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
